// File: rtl/gate_seq_pkg.sv
// Package for the gate truth-table sequencer.
// Holds the state codes, function codes, record layout and the golden gate
// model shared by the sequencer, its vector generator and the optional checker.
package gate_seq_pkg;

  // FSM state codes
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_OUT    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Function codes of the gate unit
  localparam logic [1:0] FN_BUF  = 2'd0;
  localparam logic [1:0] FN_NAND = 2'd1;
  localparam logic [1:0] FN_XNOR = 2'd2;

  localparam int REC_W    = 5;
  localparam int NUM_VECS = 10;

  // One streamed record: function, operands and the sampled output bit
  typedef struct packed {
    logic [1:0] sel;
    logic       a;
    logic       b;
    logic       out_bit;
  } rec_t;

  // Select the output of the function under test from {xnor,nand,buf}
  function automatic logic pick_out(input logic [2:0] outs, input logic [1:0] sel);
    case (sel)
      FN_BUF:  return outs[0];
      FN_NAND: return outs[1];
      FN_XNOR: return outs[2];
      default: return 1'b0;
    endcase
  endfunction

  // Expected output of an ideal gate unit
  function automatic logic golden(input logic [1:0] sel, input logic a, input logic b);
    case (sel)
      FN_BUF:  return a;
      FN_NAND: return ~(a & b);
      FN_XNOR: return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_tt_sequencer_if.sv
// Bus between the sequencer and the gate unit / record consumer.
// Carries the gate stimulus/response pair and the valid/ready record stream.
interface gate_tt_sequencer_if;
  import gate_seq_pkg::*;

  logic             rec_valid;
  logic             rec_ready;
  logic [REC_W-1:0] rec_data;
  logic [1:0]       gate_sel;
  logic             gate_a;
  logic             gate_b;
  logic [2:0]       gate_out;

  modport master (
    output rec_valid, rec_data, gate_sel, gate_a, gate_b,
    input  rec_ready, gate_out
  );

  modport slave (
    input  rec_valid, rec_data, gate_sel, gate_a, gate_b,
    output rec_ready, gate_out
  );

endinterface

// File: rtl/gate_seq_vec_gen.sv
// Vector generator for the gate sweep.
// Walks BUF a=0,1 (b held 0), then every further function through
// (a,b)=00,01,10,11. Registered outputs drive the gate unit directly, so a
// cleared generator presents all-zero stimulus.
module gate_seq_vec_gen
  import gate_seq_pkg::*;
#(
  parameter int NUM_FUNCS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       last
);

  localparam logic [1:0] LAST_SEL = 2'(NUM_FUNCS - 1);

  // Step to the next vector, rolling to the next function after its final vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= FN_BUF;
      a   <= 1'b0;
      b   <= 1'b0;
    end else if (clr) begin
      sel <= FN_BUF;
      a   <= 1'b0;
      b   <= 1'b0;
    end else if (adv) begin
      if (sel == FN_BUF) begin
        if (!a) begin
          a <= 1'b1;
        end else begin
          sel <= FN_NAND;
          a   <= 1'b0;
          b   <= 1'b0;
        end
      end else if (a && b) begin
        sel <= sel + 2'd1;
        a   <= 1'b0;
        b   <= 1'b0;
      end else begin
        {a, b} <= {a, b} + 2'd1;
      end
    end
  end

  // Final vector of the last function in the sweep
  always_comb begin
    last = 1'b0;
    if (sel == LAST_SEL) begin
      last = (sel == FN_BUF) ? a : (a & b);
    end
  end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for the BUF/NAND/XNOR gate unit.
// Drives each vector, waits SETTLE_CYC cycles, samples the selected output
// and streams one record per vector over a valid/ready port.
// Optional self-check against the golden table: define GATE_SEQ_CHECK_EN.
module gate_tt_sequencer
  import gate_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int NUM_FUNCS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
`ifdef GATE_SEQ_CHECK_EN
  output logic [3:0] err_cnt,
  output logic       pass,
`endif
  gate_tt_sequencer_if.master bus
);

  localparam int CW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

  logic [2:0]    state;
  logic [CW-1:0] settle_cnt;
  logic          start_ok;
  logic          abort_now;
  logic          settle_end;
  logic          hs;
  logic          vec_last;
  logic          vec_clr;
  logic          vec_adv;
  logic          out_bit;
  rec_t          rec_next;

  assign start_ok   = (state == ST_IDLE) && start && !abort;
  assign abort_now  = (state != ST_IDLE) && abort;
  assign settle_end = (state == ST_SETTLE) && (settle_cnt == SETTLE_LAST);
  assign hs         = (state == ST_OUT) && bus.rec_valid && bus.rec_ready;

  // Leaving a sweep (abort or final handshake) parks the generator on all-zero stimulus
  assign vec_clr = start_ok || abort_now || (hs && vec_last);
  assign vec_adv = hs && !vec_last && !abort;

  gate_seq_vec_gen #(
    .NUM_FUNCS(NUM_FUNCS)
  ) u_vec_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (vec_clr),
    .adv  (vec_adv),
    .sel  (bus.gate_sel),
    .a    (bus.gate_a),
    .b    (bus.gate_b),
    .last (vec_last)
  );

  // Assemble the record from the settled stimulus and the selected gate output
  always_comb begin
    out_bit          = pick_out(bus.gate_out, bus.gate_sel);
    rec_next         = '0;
    rec_next.sel     = bus.gate_sel;
    rec_next.a       = bus.gate_a;
    rec_next.b       = bus.gate_b;
    rec_next.out_bit = out_bit;
  end

  // Sweep control: drive, settle, hand off record, repeat until the last vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (abort_now) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_ok) begin
              state <= ST_DRIVE;
              busy  <= 1'b1;
            end
          end
          ST_DRIVE: begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_end) begin
              state <= ST_OUT;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_OUT: begin
            if (hs) begin
              if (vec_last) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_DRIVE;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Record register: captured on OUT entry, held until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rec_valid <= 1'b0;
      bus.rec_data  <= '0;
    end else if (abort_now) begin
      bus.rec_valid <= 1'b0;
      bus.rec_data  <= '0;
    end else if (settle_end) begin
      bus.rec_valid <= 1'b1;
      bus.rec_data  <= rec_next;
    end else if (hs) begin
      bus.rec_valid <= 1'b0;
    end
  end

`ifdef GATE_SEQ_CHECK_EN
  // Count mismatches against the golden table, saturating so the count never wraps to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 4'd0;
    end else if (start_ok) begin
      err_cnt <= 4'd0;
    end else if (settle_end && !abort_now &&
                 (out_bit != golden(bus.gate_sel, bus.gate_a, bus.gate_b)) &&
                 (err_cnt != 4'hF)) begin
      err_cnt <= err_cnt + 4'd1;
    end
  end

  assign pass = (err_cnt == 4'd0);
`endif

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed testbench for gate_tt_sequencer with an ideal (or faulty) gate model.
// Build with GATE_SEQ_CHECK_EN defined to also exercise the golden-table checker.
module tb_gate_tt_sequencer;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;
  logic fault;
`ifdef GATE_SEQ_CHECK_EN
  logic [3:0] err_cnt;
  logic       pass;
`endif

  int n_checks;
  int n_fail;
  int done_seen;

  logic [4:0] exp_rec [10];

  gate_tt_sequencer_if bus ();

  gate_tt_sequencer #(
    .SETTLE_CYC(2),
    .NUM_FUNCS (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
`ifdef GATE_SEQ_CHECK_EN
    .err_cnt(err_cnt),
    .pass   (pass),
`endif
    .bus    (bus)
  );

  // Gate unit model {xnor,nand,buf}; fault forces NAND(1,1)=1
  assign bus.gate_out = {~(bus.gate_a ^ bus.gate_b),
                         ~(bus.gate_a & bus.gate_b) | (fault & bus.gate_a & bus.gate_b),
                         bus.gate_a};

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses away from the active edge
  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  // Global safety net
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, bus.rec_valid} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: busy/done/valid got %b want 000", {busy, done, bus.rec_valid});
    end
    n_checks++;
    if ({bus.gate_sel, bus.gate_a, bus.gate_b} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_gate: sel/a/b got %b want 0000", {bus.gate_sel, bus.gate_a, bus.gate_b});
    end
    n_checks++;
    if (bus.rec_data !== 5'b00000) begin
      n_fail++;
      $display("[TB] FAIL reset_data: rec_data got %b want 00000", bus.rec_data);
    end
`ifdef GATE_SEQ_CHECK_EN
    n_checks++;
    if ({err_cnt, pass} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL reset_check: err_cnt/pass got %b want 00001", {err_cnt, pass});
    end
`endif
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    int d0;
    d0 = done_seen;
    bus.rec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sweep_busy: busy got %b want 1", busy);
    end
    lat = 1;
    for (int i = 0; i < 10; i++) begin
      while (bus.rec_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      n_checks++;
      if (lat != 4) begin
        n_fail++;
        $display("[TB] FAIL sweep_latency rec %0d: got %0d cycles want 4", i, lat);
      end
      n_checks++;
      if (bus.rec_data !== exp_rec[i]) begin
        n_fail++;
        $display("[TB] FAIL sweep_data rec %0d: got %b want %b", i, bus.rec_data, exp_rec[i]);
      end
      n_checks++;
      if ({bus.gate_sel, bus.gate_a, bus.gate_b} !== exp_rec[i][4:1]) begin
        n_fail++;
        $display("[TB] FAIL sweep_gate rec %0d: got %b want %b", i,
                 {bus.gate_sel, bus.gate_a, bus.gate_b}, exp_rec[i][4:1]);
      end
      tick();
      lat = 1;
    end
    n_checks++;
    if ({done, busy, bus.rec_valid} !== 3'b100) begin
      n_fail++;
      $display("[TB] FAIL sweep_done: done/busy/valid got %b want 100", {done, busy, bus.rec_valid});
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (done_seen - d0 != 1) begin
      n_fail++;
      $display("[TB] FAIL sweep_done_count: got %0d pulses want 1", done_seen - d0);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int unstable;
    int d0;
    d0 = done_seen;
    bus.rec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      while (bus.rec_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      if (i == 2) begin
        unstable = 0;
        for (int k = 0; k < 10; k++) begin
          tick();
          if (bus.rec_valid !== 1'b1 || bus.rec_data !== 5'b01001 ||
              {bus.gate_sel, bus.gate_a, bus.gate_b} !== 4'b0100) unstable++;
        end
        n_checks++;
        if (unstable != 0 || bus.rec_data !== 5'b01001) begin
          n_fail++;
          $display("[TB] FAIL bp_hold: %0d unstable cycles, rec_data got %b want 01001",
                   unstable, bus.rec_data);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (bus.rec_data !== 5'b01011) begin
          n_fail++;
          $display("[TB] FAIL bp_resume: rec_data got %b want 01011", bus.rec_data);
        end
      end
      bus.rec_ready = 1'b1;
      tick();
      bus.rec_ready = 1'b0;
    end
    bus.rec_ready = 1'b1;
    lat = 0;
    while (done_seen == d0 && lat < 200) begin
      tick();
      lat++;
    end
    n_checks++;
    if (done_seen - d0 != 1) begin
      n_fail++;
      $display("[TB] FAIL bp_finish: got %0d done pulses want 1", done_seen - d0);
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int d0;
    int seen_valid;
    d0 = done_seen;
    bus.rec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lat = 0;
      while (bus.rec_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      tick();
    end
    // now in DRIVE of vector 5; one more edge reaches SETTLE
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, bus.rec_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL abort_ctrl: busy/valid got %b want 00", {busy, bus.rec_valid});
    end
    n_checks++;
    if ({bus.gate_sel, bus.gate_a, bus.gate_b} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL abort_gate: sel/a/b got %b want 0000", {bus.gate_sel, bus.gate_a, bus.gate_b});
    end
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.rec_valid === 1'b1 || busy === 1'b1) seen_valid++;
    end
    n_checks++;
    if (done_seen != d0 || seen_valid != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_quiet: got %0d done pulses and %0d active cycles want 0 and 0",
               done_seen - d0, seen_valid);
    end
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    tick();
    n_checks++;
    if ({busy, bus.rec_valid} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL abort_wins: busy/valid got %b want 00", {busy, bus.rec_valid});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int d0;
    bus.rec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (bus.rec_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bus.rec_valid, bus.gate_sel, bus.gate_a, bus.gate_b, bus.rec_data} !== 12'd0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_values: busy/done/valid/sel/a/b/data got %b want all zero",
               {busy, done, bus.rec_valid, bus.gate_sel, bus.gate_a, bus.gate_b, bus.rec_data});
    end
    tick();
    rst_n = 1'b1;
    tick();
    d0 = done_seen;
    bus.rec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lat = 0;
      while (bus.rec_valid !== 1'b1 && lat < 40) begin
        tick();
        lat++;
      end
      n_checks++;
      if (bus.rec_valid !== 1'b1 || bus.rec_data !== exp_rec[i]) begin
        n_fail++;
        $display("[TB] FAIL rstmid_data rec %0d: valid %b data got %b want %b",
                 i, bus.rec_valid, bus.rec_data, exp_rec[i]);
      end
      tick();
    end
    tick();
    n_checks++;
    if (done_seen - d0 != 1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_done: got %0d done pulses want 1", done_seen - d0);
    end
  endtask

`ifdef GATE_SEQ_CHECK_EN
  task automatic test_checker();
    int lat;
    int d0;
    for (int run = 0; run < 2; run++) begin
      fault = (run == 0);
      d0 = done_seen;
      bus.rec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      if (run == 1) begin
        n_checks++;
        if (err_cnt !== 4'd0) begin
          n_fail++;
          $display("[TB] FAIL chk_clear: err_cnt got %0d want 0", err_cnt);
        end
      end
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
        tick();
        lat++;
      end
      n_checks++;
      if (done !== 1'b1 || err_cnt !== ((run == 0) ? 4'd1 : 4'd0) || pass !== (run == 1)) begin
        n_fail++;
        $display("[TB] FAIL chk_result run %0d: done %b err_cnt %0d pass %b want 1 %0d %0d",
                 run, done, err_cnt, pass, (run == 0) ? 1 : 0, (run == 1) ? 1 : 0);
      end
      tick();
      tick();
      n_checks++;
      if (pass !== (run == 1) || done_seen - d0 != 1) begin
        n_fail++;
        $display("[TB] FAIL chk_hold run %0d: pass %b done pulses %0d want %0d and 1",
                 run, pass, done_seen - d0, (run == 1) ? 1 : 0);
      end
    end
    fault = 1'b0;
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    fault     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    bus.rec_ready = 1'b0;
    rst_n     = 1'b0;
    exp_rec[0] = 5'b00000;
    exp_rec[1] = 5'b00101;
    exp_rec[2] = 5'b01001;
    exp_rec[3] = 5'b01011;
    exp_rec[4] = 5'b01101;
    exp_rec[5] = 5'b01110;
    exp_rec[6] = 5'b10001;
    exp_rec[7] = 5'b10010;
    exp_rec[8] = 5'b10100;
    exp_rec[9] = 5'b10111;
    #12;
    rst_n = 1'b1;
    $display("[TB] starting gate_tt_sequencer tests");
    test_reset();
    test_sweep();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef GATE_SEQ_CHECK_EN
    test_checker();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
